// File: rtl/bram_sync_fifo_if.sv
// bram_sync_fifo_if: write/read handshake, data and status bundle between a FIFO and its user
interface bram_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  we;
    logic [DATA_WIDTH-1:0] d;
    logic                  re;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output we, d, re, err_clr,
        input  q, q_valid, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  we, d, re, err_clr,
        output q, q_valid, empty, full, almost_empty, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/bram_sync_fifo.sv
// bram_sync_fifo: single-clock block-RAM FIFO with level, threshold and sticky error flags; BRAM_SYNC_FIFO_FWFT_EN selects first-word fall-through
module bram_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    bram_sync_fifo_if.slave fifo
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  vld_q, vld_d, seen_q, seen_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wa, ra, rd_en, full, empty;

    // level == DEPTH is the only value with the top bit set
    assign full = level_q[ADDR_WIDTH];
    assign wa   = fifo.we & ~full;

`ifdef BRAM_SYNC_FIFO_FWFT_EN
    logic ram_nonempty;
    // the RAM output register doubles as the head slot; fetch whenever it is free or being popped
    always_comb begin
        empty        = ~vld_q;
        ra           = fifo.re & vld_q;
        ram_nonempty = (level_q - {{ADDR_WIDTH{1'b0}}, vld_q}) != '0;
        rd_en        = ram_nonempty & (~vld_q | ra);
        vld_d        = rd_en | (vld_q & ~ra);
    end
`else
    // a RAM read is issued only for an accepted read; q_valid pulses on the following edge
    always_comb begin
        empty = level_q == '0;
        ra    = fifo.re & ~empty;
        rd_en = ra;
        vld_d = ra;
    end
`endif

    // next-state for pointers, occupancy and sticky errors (a new error beats err_clr)
    always_comb begin
        wptr_d  = wptr_q + ADDR_WIDTH'(wa);
        rptr_d  = rptr_q + ADDR_WIDTH'(rd_en);
        level_d = (wa & ~ra) ? level_q + (ADDR_WIDTH+1)'(1) :
                  (ra & ~wa) ? level_q - (ADDR_WIDTH+1)'(1) : level_q;
        seen_d  = seen_q | rd_en;
        ovf_d   = (ovf_q & ~fifo.err_clr) | (fifo.we & full);
        unf_d   = (unf_q & ~fifo.err_clr) | (fifo.re & empty);
    end

    // control state with asynchronous reset; RAM contents are left untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            vld_q   <= 1'b0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            vld_q   <= vld_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // storage with registered read and no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wa)
            mem[wptr_q] <= fifo.d;
        if (rd_en)
            rdata_q <= mem[rptr_q];
    end

    // q reads as zero until the RAM register has been loaded since reset
    always_comb begin
        fifo.q            = seen_q ? rdata_q : '0;
        fifo.q_valid      = vld_q;
        fifo.empty        = empty;
        fifo.full         = full;
        fifo.almost_empty = int'(level_q) <= AE_THRESH;
        fifo.almost_full  = int'(level_q) >= AF_THRESH;
        fifo.level        = level_q;
        fifo.overflow     = ovf_q;
        fifo.underflow    = unf_q;
    end
endmodule

// File: tb/tb_bram_sync_fifo.sv
// tb_bram_sync_fifo: directed scoreboard bench for a 16-deep, 8-bit bram_sync_fifo
module tb_bram_sync_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   m_level = 0;
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];

    bram_sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    bram_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"}, bus.empty, 1);
        chk({tag, "_full"}, bus.full, 0);
        chk({tag, "_ae"}, bus.almost_empty, 1);
        chk({tag, "_af"}, bus.almost_full, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_q"}, bus.q, 0);
        chk({tag, "_qv"}, bus.q_valid, 0);
        chk({tag, "_ovf"}, bus.overflow, 0);
        chk({tag, "_unf"}, bus.underflow, 0);
    endtask

    task automatic cyc(input logic w, input logic [7:0] wd, input logic r, input logic ec);
        logic wa, ra;
        wa = w && m_level != 16;
        ra = r && m_level != 0;
        bus.we = w; bus.d = wd; bus.re = r; bus.err_clr = ec;
        m_ovf = (m_ovf && !ec) || (w && m_level == 16);
        m_unf = (m_unf && !ec) || (r && m_level == 0);
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(wd);
        m_level = m_level + int'(wa) - int'(ra);
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0; bus.re = 1'b0; bus.err_clr = 1'b0;
        chk("q_valid", bus.q_valid, ra);
        if (bus.q_valid && exp_q.size() > 0) chk("q", bus.q, exp_q.pop_front());
        chk("level", bus.level, m_level);
        chk("empty", bus.empty, m_level == 0);
        chk("full", bus.full, m_level == 16);
        chk("almost_empty", bus.almost_empty, m_level <= 4);
        chk("almost_full", bus.almost_full, m_level >= 12);
        chk("overflow", bus.overflow, m_ovf);
        chk("underflow", bus.underflow, m_unf);
    endtask

    initial begin
        bus.we = 1'b0; bus.d = '0; bus.re = 1'b0; bus.err_clr = 1'b0;
        #1 chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef BRAM_SYNC_FIFO_FWFT_EN
        bus.we = 1'b1; bus.d = 8'hA5;
        @(posedge clk); @(negedge clk);
        bus.we = 1'b0;
        chk("fw_level1", bus.level, 1);
        chk("fw_qv_early", bus.q_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("fw_qv", bus.q_valid, 1);
        chk("fw_q", bus.q, 8'hA5);
        chk("fw_empty", bus.empty, 0);
        chk("fw_level", bus.level, 1);
        bus.re = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.re = 1'b0;
        chk("fw_qv_pop", bus.q_valid, 0);
        chk("fw_empty_pop", bus.empty, 1);
        chk("fw_level_pop", bus.level, 0);
        chk("fw_unf", bus.underflow, 0);
`else
        cyc(1, 8'h5A, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 8'h00, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        m_level = 0; m_ovf = 0; m_unf = 0;
        model_q.delete(); exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'hFF, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'h80 + 8'(i), 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 8'h90 + 8'(i), 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'hE0, 1, 0);
        cyc(0, 8'h00, 0, 1);
        for (int i = 1; i < 16; i++) cyc(1, 8'hE0 + 8'(i), 0, 0);
        cyc(1, 8'hEF, 1, 0);
        for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
